ysyx_22051110_gpr_dump: RTL

YSYX_22051110_GPR_DUMP -- requirements
Module: ysyx_22051110_GprDump

---
 rtl/ysyx_22051110_gpr_dump.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/ysyx_22051110_gpr_dump.sv
// rtl/ysyx_22051110_gpr_dump.sv - GPR dump engine streaming registers START_IDX..END_IDX, optional XOR checksum beat (YSYX_22051110_GPR_DUMP_CKSUM_EN)
module ysyx_22051110_gpr_dump #(
    parameter int START_IDX = 0,
    parameter int END_IDX   = 31
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_valid,
    output logic        start_ready,
    output logic [4:0]  rf_raddr,
    input  logic [63:0] rf_rdata,
    input  logic        rf_wen,
    input  logic [4:0]  rf_waddr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic [4:0]  out_idx,
    output logic        out_last,
    output logic        busy
);

    localparam logic [4:0] FIRST_IDX = 5'(START_IDX);
    localparam logic [4:0] LAST_IDX  = 5'(END_IDX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
`ifdef YSYX_22051110_GPR_DUMP_CKSUM_EN
        SEND  = 2'd2,
        CKSUM = 2'd3
`else
        SEND  = 2'd2
`endif
    } state_t;

    state_t      state;
    logic [4:0]  idx;
    logic [63:0] data_q;
    logic        hazard;
    logic        at_last;

`ifdef YSYX_22051110_GPR_DUMP_CKSUM_EN
    logic [63:0] cksum_q;
`endif

    // A write landing on the register being read this cycle would make
    // rf_rdata stale; x0 is hardwired so writes to it never matter.
    assign hazard  = rf_wen && (rf_waddr == idx) && (idx != 5'd0);
    assign at_last = (idx == LAST_IDX);

`ifdef YSYX_22051110_GPR_DUMP_CKSUM_EN
    // The checksum beat reuses the output lanes with index 0.
    assign out_data = (state == CKSUM) ? cksum_q : data_q;
    assign out_idx  = (state == CKSUM) ? 5'd0 : idx;
`else
    assign out_data = data_q;
    assign out_idx  = idx;
`endif

    // Dump FSM: all handshake and status outputs are registered here.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            idx         <= 5'd0;
            data_q      <= 64'd0;
            rf_raddr    <= 5'd0;
            start_ready <= 1'b1;
            busy        <= 1'b0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
`ifdef YSYX_22051110_GPR_DUMP_CKSUM_EN
            cksum_q     <= 64'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        state       <= READ;
                        idx         <= FIRST_IDX;
                        rf_raddr    <= FIRST_IDX;
                        start_ready <= 1'b0;
                        busy        <= 1'b1;
`ifdef YSYX_22051110_GPR_DUMP_CKSUM_EN
                        cksum_q     <= 64'd0;
`endif
                    end
                end

                READ: begin
                    // Hold the read address until the pending write has landed.
                    if (!hazard) begin
                        data_q    <= (idx == 5'd0) ? 64'd0 : rf_rdata;
                        rf_raddr  <= 5'd0;
                        out_valid <= 1'b1;
`ifdef YSYX_22051110_GPR_DUMP_CKSUM_EN
                        out_last  <= 1'b0;
`else
                        out_last  <= at_last;
`endif
                        state     <= SEND;
                    end
                end

                SEND: begin
                    if (out_ready) begin
`ifdef YSYX_22051110_GPR_DUMP_CKSUM_EN
                        cksum_q <= cksum_q ^ data_q;
`endif
                        if (!at_last) begin
                            idx       <= idx + 5'd1;
                            rf_raddr  <= idx + 5'd1;
                            out_valid <= 1'b0;
                            state     <= READ;
                        end else begin
`ifdef YSYX_22051110_GPR_DUMP_CKSUM_EN
                            // out_valid stays high: the checksum beat follows at once.
                            out_last  <= 1'b1;
                            state     <= CKSUM;
`else
                            out_valid   <= 1'b0;
                            out_last    <= 1'b0;
                            busy        <= 1'b0;
                            start_ready <= 1'b1;
                            state       <= IDLE;
`endif
                        end
                    end
                end

`ifdef YSYX_22051110_GPR_DUMP_CKSUM_EN
                CKSUM: begin
                    if (out_ready) begin
                        out_valid   <= 1'b0;
                        out_last    <= 1'b0;
                        busy        <= 1'b0;
                        start_ready <= 1'b1;
                        state       <= IDLE;
                    end
                end
`endif

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
